// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port word memory behind a pulse-driven request FSM.
// A read or write pulse accepted in IDLE produces exactly one mem_reply pulse
// LATENCY cycles later. Protocol violations (both pulses at once, or any
// pulse while busy) are ignored and latch the sticky mem_error flag.
// LATENCY must lie in 2..15 so that LATENCY-2 fits the 4-bit counter.
module mem_ctrl #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 31,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_pulse,
  input  logic              mem_write_pulse,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_reply,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_busy,
  output logic              mem_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    REPLY  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

  state_t            r_state;
  logic [3:0]        r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_is_write;
  logic              r_reply;
  logic              r_busy;
  logic              r_error;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  logic w_any_pulse;
  logic w_one_pulse;
  logic w_both_pulse;

  assign w_any_pulse  = mem_read_pulse | mem_write_pulse;
  assign w_one_pulse  = mem_read_pulse ^ mem_write_pulse;
  assign w_both_pulse = mem_read_pulse & mem_write_pulse;

  // Request FSM with latched request, latency counter and registered outputs.
  // NOTE: every flop here is assigned with <= so all reads in this block see
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_reply    <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_reply <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_one_pulse) begin
            r_addr     <= mem_addr;
            r_wdata    <= mem_wdata;
            r_is_write <= mem_write_pulse;
            r_count    <= CNT_LOAD;
            r_busy     <= 1'b1;
            r_state    <= ACCESS;
          end else if (w_both_pulse) begin
            r_error <= 1'b1;
          end
        end
        ACCESS: begin
          if (w_any_pulse) r_error <= 1'b1;
          if (r_count == 4'd0) begin
            r_state <= REPLY;
            r_reply <= 1'b1;
            // Reads capture the word as the reply cycle begins; writes leave
            // the previous read data on mem_rdata.
            if (!r_is_write) r_rdata <= r_mem[r_addr];
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        REPLY: begin
          if (w_any_pulse) r_error <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: a write commits on the edge that ends the REPLY cycle.
  // NOTE: the array has no reset branch; contents survive reset, and only the
  // commit itself is suppressed while reset is asserted so an aborted write
  // never lands.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == REPLY) && r_is_write) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign mem_reply = r_reply;
  assign mem_rdata = r_rdata;
  assign mem_busy  = r_busy;
  assign mem_error = r_error;

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have the parameter ADDR_W, default 11, meaning the word address width (2048 words).
REQ-002 The block SHALL have the parameter DATA_W, default 31, meaning the machine word width.
REQ-003 The block SHALL have the parameter LATENCY, default 3, meaning the cycles from accepted pulse to reply; legal range 2..15.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mem_read_pulse  input  1  one-cycle read request from the pulse sequencer.
REQ-007 mem_write_pulse  input  1  one-cycle write request from the pulse sequencer.
REQ-008 mem_addr  input  ADDR_W  word address, sampled with the request pulse.
REQ-009 mem_wdata  input  DATA_W  write data, sampled with the request pulse.
REQ-010 mem_reply  output  1  one-cycle completion pulse back to the sequencer.
REQ-011 mem_rdata  output  DATA_W  read data, valid from the reply cycle onward.
REQ-012 mem_busy  output  1  high while a request is outstanding.
REQ-013 mem_error  output  1  sticky protocol-violation flag.

Function
REQ-014 The block SHALL contain a 2^ADDR_W x DATA_W storage array; array contents are not cleared by reset.
REQ-015 The FSM SHALL have the states IDLE, ACCESS and REPLY; the reset state is IDLE.
REQ-016 In IDLE, exactly one of mem_read_pulse / mem_write_pulse high in cycle T SHALL latch mem_addr, mem_wdata and the op type, load the latency counter with LATENCY-2, and enter ACCESS at T+1.
REQ-017 In ACCESS, the counter SHALL decrement each cycle; at zero the FSM SHALL enter REPLY on the next edge.
REQ-018 In REPLY, mem_reply SHALL be high for exactly that one cycle (cycle T+LATENCY); the FSM SHALL return to IDLE on the next edge.
REQ-019 A write SHALL commit the latched data to the latched address on the edge ending the REPLY cycle.
REQ-020 A read SHALL drive mem_rdata with the array word at the latched address during the REPLY cycle and SHALL hold it until the next read reply; writes SHALL not change mem_rdata.
REQ-021 A read issued in the cycle immediately after a write reply SHALL return the newly written data.
REQ-022 mem_busy SHALL be high in ACCESS and REPLY, and low in IDLE.
REQ-023 A new pulse is accepted in the IDLE cycle following REPLY, giving a minimum request spacing of LATENCY+1 cycles.
REQ-024 Both pulses high in the same IDLE cycle SHALL cause no access, no reply, and mem_error set.
REQ-025 Any request pulse while mem_busy is high SHALL be ignored (the in-flight request is unaffected) and SHALL set mem_error.
REQ-026 mem_error SHALL stay set until reset.
REQ-027 Address arithmetic: none; out-of-range is impossible by width; no wrap logic is required.

Reset
REQ-028 Reset SHALL force IDLE, counter 0, mem_reply 0, mem_busy 0, mem_error 0, mem_rdata 0, and latched addr/data/op cleared.
REQ-029 Reset asserted mid-operation SHALL abort the request: no reply is produced and a pending write is discarded (the array is unchanged).
REQ-030 Reset SHALL take priority over any simultaneous request pulse; that pulse is dropped.

Verification
REQ-031 Write then read (LATENCY=3): write pulse at T0, addr=0x005, wdata=0x1234_5678 -> reply at T0+3 only; read pulse at T0+4, addr=0x005 -> reply at T0+7 with mem_rdata=0x1234_5678.
REQ-032 Busy collision: read pulse at T0, then write pulse at T0+1 -> mem_error=1 from T0+2; the read reply still occurs at T0+3; the write is not committed.
REQ-033 Simultaneous pulses: read and write high at T0, addr=0x010 -> no reply within 10 cycles, mem_error=1, mem_busy stays 0.
REQ-034 Reset mid-write: write pulse at T0, addr=0x020, data=0x7FFF_FFFF, reset at T0+1 -> no reply; a subsequent read of 0x020 returns the prior contents.
REQ-035 Back-to-back reads at minimum spacing: reads at T0 and T0+4 to addrs 0x000 and 0x7FF -> replies at T0+3 and T0+7 with the correct words; mem_error remains 0.
REQ-036 Sequencer loop: connect to the pulse sequencer and run three read cycles -> each mem_read_pulse yields exactly one mem_reply, and there are no lost or duplicated replies.
